// File: rtl/xor_bind_checker.sv
// Bound-in monitor for an XOR datapath: rebuilds a ^ b through a LAT-deep
// expected pipe and compares it with the observed c, keeping saturating stats.
module xor_bind_checker #(
  parameter int CNT_W = 8,
  parameter int LAT   = 0
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             a,
  input  logic             b,
  input  logic             c,
  input  logic             en,
  input  logic             clr,
  output logic             busy,
  output logic [CNT_W-1:0] sample_cnt,
  output logic [CNT_W-1:0] err_cnt,
  output logic             err,
  output logic [CNT_W-1:0] first_err_idx
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FILL  = 2'd1,
    CHECK = 2'd2
  } state_t;

  localparam logic [CNT_W-1:0] CNT_MAX = '1;
  localparam logic [1:0]       LAT_L   = 2'(LAT);

  // Handshake: none. en marks one sample per cycle and is never back-pressured;
  // clr wins over a simultaneous en and discards that sample.

  state_t     state;
  state_t     state_nx;
  logic [1:0] fill_cnt;
  logic [1:0] fill_nx;
  logic       do_cmp;
  logic       cur_x;
  logic       exp_bit;
  logic       mismatch;

  assign cur_x    = a ^ b;
  assign mismatch = c ^ exp_bit;

  generate
    if (LAT == 0) begin : g_no_pipe
      assign exp_bit = cur_x;
    end else begin : g_pipe
      // pipe[0] holds the newest sample, pipe[LAT-1] the one LAT samples back.
      logic [LAT-1:0] pipe;
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          pipe <= '0;
        end else if (clr) begin
          pipe <= '0;
        end else if (en) begin
          pipe <= LAT'({pipe, cur_x});
        end
      end
      assign exp_bit = pipe[LAT-1];
    end
  endgenerate

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      fill_cnt <= 2'd0;
      busy     <= 1'b0;
    end else begin
      state    <= state_nx;
      fill_cnt <= fill_nx;
      busy     <= (state_nx != IDLE);
    end
  end

  always_comb begin
    state_nx = state;
    fill_nx  = fill_cnt;
    do_cmp   = 1'b0;
    if (clr) begin
      state_nx = IDLE;
      fill_nx  = 2'd0;
    end else if (en) begin
      case (state)
        IDLE: begin
          if (LAT == 0) begin
            state_nx = CHECK;
            do_cmp   = 1'b1;
          end else begin
            fill_nx  = 2'd1;
            state_nx = (LAT_L == 2'd1) ? CHECK : FILL;
          end
        end
        FILL: begin
          fill_nx  = fill_cnt + 2'd1;
          state_nx = (fill_nx == LAT_L) ? CHECK : FILL;
        end
        CHECK: begin
          do_cmp = 1'b1;
        end
        default: begin
          state_nx = IDLE;
          fill_nx  = 2'd0;
        end
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sample_cnt    <= '0;
      err_cnt       <= '0;
      err           <= 1'b0;
      first_err_idx <= '0;
    end else if (clr) begin
      sample_cnt    <= '0;
      err_cnt       <= '0;
      err           <= 1'b0;
      first_err_idx <= '0;
    end else if (do_cmp) begin
      if (sample_cnt != CNT_MAX) sample_cnt <= sample_cnt + 1'b1;
      if (mismatch) begin
        if (err_cnt != CNT_MAX) err_cnt <= err_cnt + 1'b1;
        err <= 1'b1;
        // Index is the pre-increment count, so the first compare is index 0.
        if (!err) first_err_idx <= sample_cnt;
      end
    end
  end

endmodule

// File: tb/tb_xor_bind_checker.sv
// Bench for xor_bind_checker: four instances with different LAT/CNT_W share
// stimulus; a sample-history model predicts every output after each edge.
module tb_xor_bind_checker;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst_n, a, b, en, clr;
  logic c [4];
  logic busy_o [4];
  logic err_o [4];
  logic [7:0] sc_o [4];
  logic [7:0] ec_o [4];
  logic [7:0] fi_o [4];
  logic [1:0] sc2, ec2, fi2;
  logic [3:0] sc3, ec3, fi3;

  assign sc_o[2] = {6'd0, sc2};
  assign ec_o[2] = {6'd0, ec2};
  assign fi_o[2] = {6'd0, fi2};
  assign sc_o[3] = {4'd0, sc3};
  assign ec_o[3] = {4'd0, ec3};
  assign fi_o[3] = {4'd0, fi3};

  xor_bind_checker #(.CNT_W(8), .LAT(0)) u_l0 (
    .clk(clk), .rst_n(rst_n), .a(a), .b(b), .c(c[0]), .en(en), .clr(clr),
    .busy(busy_o[0]), .sample_cnt(sc_o[0]), .err_cnt(ec_o[0]), .err(err_o[0]),
    .first_err_idx(fi_o[0]));
  xor_bind_checker #(.CNT_W(8), .LAT(2)) u_l2 (
    .clk(clk), .rst_n(rst_n), .a(a), .b(b), .c(c[1]), .en(en), .clr(clr),
    .busy(busy_o[1]), .sample_cnt(sc_o[1]), .err_cnt(ec_o[1]), .err(err_o[1]),
    .first_err_idx(fi_o[1]));
  xor_bind_checker #(.CNT_W(2), .LAT(0)) u_w2 (
    .clk(clk), .rst_n(rst_n), .a(a), .b(b), .c(c[2]), .en(en), .clr(clr),
    .busy(busy_o[2]), .sample_cnt(sc2), .err_cnt(ec2), .err(err_o[2]),
    .first_err_idx(fi2));
  xor_bind_checker #(.CNT_W(4), .LAT(1)) u_l1 (
    .clk(clk), .rst_n(rst_n), .a(a), .b(b), .c(c[3]), .en(en), .clr(clr),
    .busy(busy_o[3]), .sample_cnt(sc3), .err_cnt(ec3), .err(err_o[3]),
    .first_err_idx(fi3));

  int lat_of [4] = '{0, 2, 0, 1};
  int max_of [4] = '{255, 255, 3, 15};

  // Reference model: history of a^b per enabled sample since start/clear.
  int n_en [4];
  bit hist [4][$];
  int m_sc [4];
  int m_ec [4];
  int m_fi [4];
  bit m_err [4];
  int cmode [4];  // 0 good, 1 stuck 0, 2 random, 3 inverted
  int errors;
  int checks;

  task automatic model_reset();
    for (int i = 0; i < 4; i++) begin
      n_en[i] = 0;
      hist[i].delete();
      m_sc[i] = 0;
      m_ec[i] = 0;
      m_fi[i] = 0;
      m_err[i] = 1'b0;
    end
  endtask

  task automatic step(input bit en_v, input bit a_v, input bit b_v, input bit clr_v);
    @(negedge clk);
    en = en_v; a = a_v; b = b_v; clr = clr_v;
    for (int i = 0; i < 4; i++) begin
      int k;
      bit e;
      bit cmp;
      bit rnd;
      k = n_en[i];
      e = 1'b0;
      rnd = 1'($urandom_range(0, 1));
      cmp = en_v && !clr_v && (k >= lat_of[i]);
      if (en_v && !clr_v) hist[i].push_back(a_v ^ b_v);
      if (cmp) e = hist[i][k - lat_of[i]];
      case (cmode[i])
        0: c[i] = cmp ? e : rnd;
        1: c[i] = 1'b0;
        3: c[i] = cmp ? ~e : rnd;
        default: c[i] = rnd;
      endcase
      if (cmp) begin
        if (c[i] != e) begin
          if (!m_err[i]) m_fi[i] = m_sc[i];
          m_err[i] = 1'b1;
          if (m_ec[i] < max_of[i]) m_ec[i]++;
        end
        if (m_sc[i] < max_of[i]) m_sc[i]++;
      end
      if (en_v && !clr_v) n_en[i]++;
    end
    if (clr_v) model_reset();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; en = 1'b0; clr = 1'b0; a = 1'b0; b = 1'b0;
    for (int i = 0; i < 4; i++) begin c[i] = 1'b0; cmode[i] = 0; end
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    for (int i = 0; i < 4; i++) begin
      checks++; if (busy_o[i] !== 1'b0) begin errors++; $display("FAIL reset u%0d busy got=%0b exp=0", i, busy_o[i]); end
      checks++; if (sc_o[i] !== 8'd0) begin errors++; $display("FAIL reset u%0d sample_cnt got=%0d exp=0", i, sc_o[i]); end
      checks++; if (ec_o[i] !== 8'd0) begin errors++; $display("FAIL reset u%0d err_cnt got=%0d exp=0", i, ec_o[i]); end
      checks++; if (err_o[i] !== 1'b0) begin errors++; $display("FAIL reset u%0d err got=%0b exp=0", i, err_o[i]); end
      checks++; if (fi_o[i] !== 8'd0) begin errors++; $display("FAIL reset u%0d first_err_idx got=%0d exp=0", i, fi_o[i]); end
    end
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_lat0_good();
    for (int i = 0; i < 4; i++) cmode[i] = 0;
    step(1'b0, 1'b0, 1'b0, 1'b1);
    for (int n = 0; n < 10; n++) step(1'b1, n[1], n[0], 1'b0);
    checks++; if (sc_o[0] !== 8'd10) begin errors++; $display("FAIL lat0_good sample_cnt got=%0d exp=10", sc_o[0]); end
    for (int i = 0; i < 4; i++) begin
      checks++; if (sc_o[i] !== 8'(m_sc[i])) begin errors++; $display("FAIL lat0_good u%0d sample_cnt got=%0d exp=%0d", i, sc_o[i], m_sc[i]); end
      checks++; if (ec_o[i] !== 8'd0) begin errors++; $display("FAIL lat0_good u%0d err_cnt got=%0d exp=0", i, ec_o[i]); end
      checks++; if (err_o[i] !== 1'b0) begin errors++; $display("FAIL lat0_good u%0d err got=%0b exp=0", i, err_o[i]); end
      checks++; if (busy_o[i] !== 1'b1) begin errors++; $display("FAIL lat0_good u%0d busy got=%0b exp=1", i, busy_o[i]); end
    end
  endtask

  task automatic test_lat0_stuck();
    for (int i = 0; i < 4; i++) cmode[i] = 1;
    step(1'b0, 1'b0, 1'b0, 1'b1);
    for (int n = 0; n < 4; n++) step(1'b1, n[1], n[0], 1'b0);
    checks++; if (ec_o[0] !== 8'd2) begin errors++; $display("FAIL lat0_stuck err_cnt got=%0d exp=2", ec_o[0]); end
    checks++; if (err_o[0] !== 1'b1) begin errors++; $display("FAIL lat0_stuck err got=%0b exp=1", err_o[0]); end
    checks++; if (fi_o[0] !== 8'd1) begin errors++; $display("FAIL lat0_stuck first_err_idx got=%0d exp=1", fi_o[0]); end
    for (int i = 0; i < 4; i++) begin
      checks++; if (ec_o[i] !== 8'(m_ec[i])) begin errors++; $display("FAIL lat0_stuck u%0d err_cnt got=%0d exp=%0d", i, ec_o[i], m_ec[i]); end
      checks++; if (fi_o[i] !== 8'(m_fi[i])) begin errors++; $display("FAIL lat0_stuck u%0d first_err_idx got=%0d exp=%0d", i, fi_o[i], m_fi[i]); end
      checks++; if (err_o[i] !== m_err[i]) begin errors++; $display("FAIL lat0_stuck u%0d err got=%0b exp=%0b", i, err_o[i], m_err[i]); end
    end
  endtask

  task automatic test_lat2_gaps();
    bit en_seq [6] = '{1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1};
    for (int i = 0; i < 4; i++) cmode[i] = 0;
    step(1'b0, 1'b0, 1'b0, 1'b1);
    for (int n = 0; n < 6; n++) begin
      step(en_seq[n], 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 1'b0);
      if (n == 0) begin
        checks++; if (busy_o[1] !== 1'b1) begin errors++; $display("FAIL lat2_gaps busy got=%0b exp=1", busy_o[1]); end
        checks++; if (sc_o[1] !== 8'd0) begin errors++; $display("FAIL lat2_gaps early sample_cnt got=%0d exp=0", sc_o[1]); end
      end
    end
    checks++; if (sc_o[1] !== 8'd2) begin errors++; $display("FAIL lat2_gaps sample_cnt got=%0d exp=2", sc_o[1]); end
    checks++; if (ec_o[1] !== 8'd0) begin errors++; $display("FAIL lat2_gaps err_cnt got=%0d exp=0", ec_o[1]); end
    for (int i = 0; i < 4; i++) begin
      checks++; if (sc_o[i] !== 8'(m_sc[i])) begin errors++; $display("FAIL lat2_gaps u%0d sample_cnt got=%0d exp=%0d", i, sc_o[i], m_sc[i]); end
      checks++; if (err_o[i] !== m_err[i]) begin errors++; $display("FAIL lat2_gaps u%0d err got=%0b exp=%0b", i, err_o[i], m_err[i]); end
    end
  endtask

  task automatic test_saturation();
    for (int i = 0; i < 4; i++) cmode[i] = 3;
    step(1'b0, 1'b0, 1'b0, 1'b1);
    for (int n = 0; n < 6; n++) step(1'b1, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 1'b0);
    checks++; if (sc2 !== 2'd3) begin errors++; $display("FAIL saturation sample_cnt got=%0d exp=3", sc2); end
    checks++; if (ec2 !== 2'd3) begin errors++; $display("FAIL saturation err_cnt got=%0d exp=3", ec2); end
    checks++; if (fi2 !== 2'd0) begin errors++; $display("FAIL saturation first_err_idx got=%0d exp=0", fi2); end
    checks++; if (err_o[2] !== 1'b1) begin errors++; $display("FAIL saturation err got=%0b exp=1", err_o[2]); end
    for (int i = 0; i < 4; i++) begin
      checks++; if (sc_o[i] !== 8'(m_sc[i])) begin errors++; $display("FAIL saturation u%0d sample_cnt got=%0d exp=%0d", i, sc_o[i], m_sc[i]); end
      checks++; if (ec_o[i] !== 8'(m_ec[i])) begin errors++; $display("FAIL saturation u%0d err_cnt got=%0d exp=%0d", i, ec_o[i], m_ec[i]); end
    end
  endtask

  task automatic test_clr();
    for (int i = 0; i < 4; i++) cmode[i] = 3;
    step(1'b1, 1'b1, 1'b0, 1'b1);
    for (int i = 0; i < 4; i++) begin
      checks++; if (busy_o[i] !== 1'b0) begin errors++; $display("FAIL clr u%0d busy got=%0b exp=0", i, busy_o[i]); end
      checks++; if (sc_o[i] !== 8'd0) begin errors++; $display("FAIL clr u%0d sample_cnt got=%0d exp=0", i, sc_o[i]); end
      checks++; if (ec_o[i] !== 8'd0) begin errors++; $display("FAIL clr u%0d err_cnt got=%0d exp=0", i, ec_o[i]); end
      checks++; if (err_o[i] !== 1'b0) begin errors++; $display("FAIL clr u%0d err got=%0b exp=0", i, err_o[i]); end
      checks++; if (fi_o[i] !== 8'd0) begin errors++; $display("FAIL clr u%0d first_err_idx got=%0d exp=0", i, fi_o[i]); end
    end
  endtask

  task automatic test_async_reset();
    for (int i = 0; i < 4; i++) cmode[i] = 0;
    step(1'b0, 1'b0, 1'b0, 1'b1);
    step(1'b1, 1'b0, 1'b1, 1'b0);
    step(1'b1, 1'b1, 1'b1, 1'b0);
    cmode[0] = 3;
    step(1'b1, 1'b1, 1'b0, 1'b0);
    checks++; if (ec_o[0] !== 8'd1) begin errors++; $display("FAIL async_reset pre err_cnt got=%0d exp=1", ec_o[0]); end
    @(negedge clk);
    en = 1'b0;
    #2 rst_n = 1'b0;
    model_reset();
    #1;
    for (int i = 0; i < 4; i++) begin
      checks++; if (busy_o[i] !== 1'b0) begin errors++; $display("FAIL async_reset u%0d busy got=%0b exp=0", i, busy_o[i]); end
      checks++; if (ec_o[i] !== 8'd0) begin errors++; $display("FAIL async_reset u%0d err_cnt got=%0d exp=0", i, ec_o[i]); end
      checks++; if (err_o[i] !== 1'b0) begin errors++; $display("FAIL async_reset u%0d err got=%0b exp=0", i, err_o[i]); end
      checks++; if (sc_o[i] !== 8'd0) begin errors++; $display("FAIL async_reset u%0d sample_cnt got=%0d exp=0", i, sc_o[i]); end
    end
    #1 rst_n = 1'b1;
    cmode[0] = 0;
    step(1'b1, 1'b1, 1'b0, 1'b0);
    checks++; if (sc_o[0] !== 8'd1) begin errors++; $display("FAIL async_reset post sample_cnt got=%0d exp=1", sc_o[0]); end
    checks++; if (ec_o[0] !== 8'd0) begin errors++; $display("FAIL async_reset post err_cnt got=%0d exp=0", ec_o[0]); end
  endtask

  task automatic test_random();
    step(1'b0, 1'b0, 1'b0, 1'b1);
    for (int n = 0; n < 400; n++) begin
      if (n % 50 == 0)
        for (int i = 0; i < 4; i++) cmode[i] = int'($urandom_range(0, 3));
      step(($urandom_range(0, 9) < 7), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
           ($urandom_range(0, 39) == 0));
      for (int i = 0; i < 4; i++) begin
        checks++; if (busy_o[i] !== (n_en[i] > 0)) begin errors++; $display("FAIL random n%0d u%0d busy got=%0b exp=%0b", n, i, busy_o[i], (n_en[i] > 0)); end
        checks++; if (sc_o[i] !== 8'(m_sc[i])) begin errors++; $display("FAIL random n%0d u%0d sample_cnt got=%0d exp=%0d", n, i, sc_o[i], m_sc[i]); end
        checks++; if (ec_o[i] !== 8'(m_ec[i])) begin errors++; $display("FAIL random n%0d u%0d err_cnt got=%0d exp=%0d", n, i, ec_o[i], m_ec[i]); end
        checks++; if (err_o[i] !== m_err[i]) begin errors++; $display("FAIL random n%0d u%0d err got=%0b exp=%0b", n, i, err_o[i], m_err[i]); end
        checks++; if (fi_o[i] !== 8'(m_fi[i])) begin errors++; $display("FAIL random n%0d u%0d first_err_idx got=%0d exp=%0d", n, i, fi_o[i], m_fi[i]); end
      end
    end
  endtask

  initial begin
    errors = 0;
    checks = 0;
    test_reset();
    test_lat0_good();
    test_lat0_stuck();
    test_lat2_gaps();
    test_saturation();
    test_clr();
    test_async_reset();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/xor_bind_checker.md
# xor_bind_checker

Self-checking monitor, the observing end of a bound-in XOR datapath. It is attached with `bind` into a target whose ports `a`, `b`, `c` carry operands and result; connection uses `.*`. It samples the target's pins, rebuilds the expected `a ^ b` through a configurable latency pipe, and compares it against the observed `c`. It keeps saturating sample and mismatch counts, a sticky error flag and the index of the first failure, so a flattened design plus an equivalence or simulation run can expose a missing or wrong binding.

## Interface
- `CNT_W`, 8, width of all counters and the captured index (2..16)
- `LAT`, 0, cycles between operand sample and result appearing on `c` (0..3)
- `clk`  in  1  single clock, rising edge
- `rst_n`  in  1  asynchronous active-low reset
- `a`  in  1  operand A, bound from target
- `b`  in  1  operand B, bound from target
- `c`  in  1  observed result, bound from target
- `en`  in  1  sample enable; a cycle with `en=1` is one sample
- `clr`  in  1  synchronous clear of all state
- `busy`  out  1  high in FILL or CHECK
- `sample_cnt`  out  CNT_W  compared samples, saturating
- `err_cnt`  out  CNT_W  mismatching samples, saturating
- `err`  out  1  sticky: any mismatch since reset/clear
- `first_err_idx`  out  CNT_W  `sample_cnt` value at the first mismatch

## Operation
- Reset (`rst_n=0`, async): state IDLE. All outputs 0. Expected pipe 0. Fill counter 0.
- FSM states:
  - IDLE: on `en=1` go FILL if `LAT>0`, else CHECK. That sample is processed per the target state's rules in the same cycle.
  - FILL: the pipe shifts on each `en`. After `LAT` enabled samples, including the one that left IDLE, go CHECK. No compares are made.
  - CHECK: stays until `clr` or reset.
- Expected pipe: `LAT`-deep shift register of `a ^ b`. It advances only on `en=1`. With `LAT=0` the expected value is the combinational `a ^ b` of the current cycle.
- Compare, CHECK only, on `en=1`: mismatch = `c != expected`, where expected is the value from `LAT` enabled samples earlier.
  - `sample_cnt` +1, saturating at 2^CNT_W-1.
  - On mismatch: `err_cnt` +1 (saturating) and `err` set to 1.
  - If `err` was 0, `first_err_idx` <= current `sample_cnt` (pre-increment value). The first compared sample has index 0.
- Saturation: once `sample_cnt` is all-ones, it holds. Later mismatches still increment `err_cnt` (until it saturates too). `first_err_idx` then captures all-ones.
- `clr=1`: next edge returns to IDLE and zeroes the counters, `err`, `first_err_idx`, the pipe and the fill counter. `clr` beats a simultaneous `en`; that sample is discarded.
- `en=0` cycles: no state change and no shift. Gaps between samples are allowed in every state.
- `busy` = (state != IDLE), registered.

## Timing
- All outputs are registered. Effects of a sample taken at edge k are visible after edge k.
- Latency from first `en` to first compare:
  - `LAT=0`: the first sample is compared.
  - `LAT=N`: the (N+1)th enabled sample is compared.
- Async reset mid-FILL or mid-CHECK: everything returns to reset values immediately. Operation restarts from IDLE after `rst_n` deasserts, with no edge needed to clear.
- `en` is not qualified by `busy`. The monitor never back-pressures.

## Test plan
- LAT=0, correct binding: 10 cycles `en=1`, all four `a,b` combos, `c=a^b` -> `sample_cnt=10`, `err_cnt=0`, `err=0`.
- LAT=0, `c` stuck 0 (empty target, no bind): inputs a,b = 00,01,10,11 -> `err_cnt=2`, `err=1`, `first_err_idx=1`.
- LAT=2, `c` driven as a^b delayed two enabled samples, `en` toggling 1,0,1,1,0,1: no errors. `busy=1` after the first `en`. First compare happens on the third enabled sample; `sample_cnt=2` at the end.
- CNT_W=2, 6 samples all mismatching -> `sample_cnt=3`, `err_cnt=3`, `first_err_idx=0`, `err=1`.
- After errors, assert `clr` together with `en` and a mismatching `c` -> next cycle all outputs 0, state IDLE, `busy=0`.
- Pull `rst_n` low asynchronously mid-CHECK with `err_cnt=1` -> outputs read 0 before the next edge. After release, the first good sample gives `sample_cnt=1`.
